key_note_scheduler: RTL
=======================

KEY_NOTE_SCHEDULER -- requirements
Module: key_note_scheduler

Interface
REQ-001 The block SHALL have parameter CNT_W, default 18, meaning tone half-period width in CLK cycles.
REQ-002 The block SHALL have parameter TIMEOUT_CYC, default 100_000, meaning maximum CLK cycles a prefix state may wait for its next byte.
REQ-003 The block SHALL have port CLK, input, 1, system clock (50 MHz); all logic is on its rising edge.
REQ-004 The block SHALL have port RST, input, 1, asynchronous active-high reset.
REQ-005 The block SHALL have port ps2_byte, input, 8, received scan-code byte.
REQ-006 The block SHALL have port ps2_valid, input, 1, one-cycle strobe qualifying ps2_byte.
REQ-007 The block SHALL have port tone_period, output, CNT_W, half-period for the tone generator; 0 = silence.
REQ-008 The block SHALL have port tone_req, output, 1, request to load tone_period.
REQ-009 The block SHALL have port tone_ack, input, 1, tone generator accepted tone_period.
REQ-010 The block SHALL have port key_held, output, 8, one bit per mapped key, set while held.
REQ-011 The block SHALL have port note_on, output, 1, high when at least one mapped key is held.

Function
REQ-012 Key map (index: code -> half-period): 0:1C->95557, 1:1B->85131, 2:23->75843, 3:2B->71586, 4:34->63776, 5:33->56818, 6:3B->50619, 7:42->47778; other codes are unmapped.
REQ-013 The parser FSM SHALL have four states: IDLE, BRK (after F0), EXT (after E0), EXTBRK (after E0 F0).
REQ-014 In IDLE: F0->BRK, E0->EXT; a mapped code is a make event; other bytes are ignored; the FSM stays in IDLE.
REQ-015 In BRK: any byte other than E0/F0 is a break event for that code, then the FSM returns to IDLE; E0/F0 in BRK returns to IDLE with no event.
REQ-016 In EXT: F0->EXTBRK; any other byte is discarded and the FSM returns to IDLE; in EXTBRK any byte is discarded and the FSM returns to IDLE.
REQ-017 A non-IDLE state with no ps2_valid for TIMEOUT_CYC consecutive cycles SHALL return to IDLE with no event.
REQ-018 A make SHALL set key_held[i] and make key i active; a repeated make of the already-active key SHALL change nothing.
REQ-019 A break SHALL clear key_held[i]; if i was active, the lowest-index still-held key becomes active; if none remain held, the desired period is 0.
REQ-020 A break of a key not held SHALL be ignored.
REQ-021 key_held and note_on SHALL update the cycle after the ps2_valid cycle.
REQ-022 desired period = map[active] when note_on, else 0.
REQ-023 tone_req SHALL rise one cycle after desired differs from the last-acknowledged period and req is low, i.e. at the earliest 2 cycles after ps2_valid.
REQ-024 tone_period SHALL be stable while tone_req is high.
REQ-025 On tone_ack while tone_req is high: the last-acknowledged period latches tone_period, and tone_req drops the next cycle.
REQ-026 If desired changed while req was pending, tone_req SHALL reassert with the new value after at least one low cycle.
REQ-027 tone_ack while tone_req is low SHALL be ignored.
REQ-028 Simultaneous ps2_valid and tone_ack SHALL both be honoured in the same cycle.

Reset
REQ-029 While RST is high: FSM=IDLE, timeout counter=0, key_held=0, note_on=0, tone_req=0, tone_period=0, last-acknowledged=0, octave=0, all taking effect immediately, including mid-handshake.
REQ-030 After RST falls, no tone_req SHALL occur until a make event.

Configuration
REQ-031 With OCTAVE_SHIFT_EN defined, make of 1A decrements the octave and make of 22 increments it, saturating in the range -1..+1; the desired period = map<<1 at -1, map at 0, map>>1 at +1; an octave change while a note is on re-requests the period.
REQ-032 Without OCTAVE_SHIFT_EN, 1A and 22 are unmapped, there is no octave register, and the map is used unshifted.

Verification
REQ-033 Reset, then bytes 1C with tone_ack tied high -> tone_period=95557 and tone_req pulse, key_held=0000_0001, note_on=1.
REQ-034 Sequence 1C, 34, F0 34 -> tone_period sequence 95557, 63776, 95557; then F0 1C -> tone_period=0 and note_on=0.
REQ-035 1C sent while tone_ack is held low, then 23 -> tone_period stays 95557 until ack; after ack, req low 1 cycle, then req with 75843.
REQ-036 Sequence F0 followed by TIMEOUT_CYC idle cycles then 1C -> make of 1C (not a break); sequence E0 F0 1C -> no change.
REQ-037 With OCTAVE_SHIFT_EN, 22 22 then 33 -> 28409; then 1A 1A 1A -> 113636; without the macro, 22 -> no req.
REQ-038 RST asserted while tone_req=1 -> tone_req=0 and key_held=0 in the same cycle, and a later tone_ack produces no effect.

Source files
------------

// File: rtl/key_note_scheduler.sv
// PS/2 scan-code parser driving a single-voice tone request/ack handshake.
// Optional OCTAVE_SHIFT_EN adds 1A/22 octave down/up keys.
module key_note_scheduler #(
    parameter int CNT_W       = 18,
    parameter int TIMEOUT_CYC = 100_000
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [7:0]       ps2_byte,
    input  logic             ps2_valid,
    output logic [CNT_W-1:0] tone_period,
    output logic             tone_req,
    input  logic             tone_ack,
    output logic [7:0]       key_held,
    output logic             note_on
);

    localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    typedef enum logic [1:0] {IDLE, BRK, EXT, EXTBRK} state_t;

    state_t           state;
    logic [TW-1:0]    tmo;
    logic [2:0]       active;
    logic [CNT_W-1:0] last_ack;
    logic [CNT_W-1:0] desired;
    logic [CNT_W-1:0] base;
    logic             mk;
    logic             brk;
    logic             hit;
    logic [2:0]       idx;
    logic [7:0]       held_n;
    logic [2:0]       act_n;

    function automatic logic [3:0] lookup(input logic [7:0] b);
        case (b)
            8'h1C:   return 4'b1_000;
            8'h1B:   return 4'b1_001;
            8'h23:   return 4'b1_010;
            8'h2B:   return 4'b1_011;
            8'h34:   return 4'b1_100;
            8'h33:   return 4'b1_101;
            8'h3B:   return 4'b1_110;
            8'h42:   return 4'b1_111;
            default: return 4'b0_000;
        endcase
    endfunction

    function automatic logic [CNT_W-1:0] base_period(input logic [2:0] i);
        case (i)
            3'd0:    return CNT_W'(95557);
            3'd1:    return CNT_W'(85131);
            3'd2:    return CNT_W'(75843);
            3'd3:    return CNT_W'(71586);
            3'd4:    return CNT_W'(63776);
            3'd5:    return CNT_W'(56818);
            3'd6:    return CNT_W'(50619);
            default: return CNT_W'(47778);
        endcase
    endfunction

    function automatic logic [2:0] lowest(input logic [7:0] h);
        logic [2:0] r;
        r = 3'd0;
        for (int i = 7; i >= 0; i--)
            if (h[i]) r = 3'(i);
        return r;
    endfunction

    always_comb begin
        mk  = 1'b0;
        brk = 1'b0;
        if (ps2_valid) begin
            if (state == IDLE && ps2_byte != 8'hF0 && ps2_byte != 8'hE0)
                mk = 1'b1;
            if (state == BRK && ps2_byte != 8'hF0 && ps2_byte != 8'hE0)
                brk = 1'b1;
        end
        {hit, idx} = lookup(ps2_byte);
    end

    always_comb begin
        held_n = key_held;
        act_n  = active;
        if (mk && hit) begin
            held_n[idx] = 1'b1;
            act_n       = idx;
        end else if (brk && hit && key_held[idx]) begin
            held_n[idx] = 1'b0;
            if (idx == active) act_n = lowest(held_n);
        end
    end

`ifdef OCTAVE_SHIFT_EN
    logic signed [1:0] octave;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            octave <= 2'sd0;
        end else if (mk && ps2_byte == 8'h1A && octave != -2'sd1) begin
            octave <= octave - 2'sd1;
        end else if (mk && ps2_byte == 8'h22 && octave != 2'sd1) begin
            octave <= octave + 2'sd1;
        end
    end

    always_comb begin
        base = base_period(active);
        if (octave == -2'sd1)     base = base << 1;
        else if (octave == 2'sd1) base = base >> 1;
        desired = note_on ? base : '0;
    end
`else
    always_comb begin
        base    = base_period(active);
        desired = note_on ? base : '0;
    end
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= IDLE;
            tmo      <= '0;
            key_held <= '0;
            active   <= '0;
            note_on  <= 1'b0;
        end else begin
            key_held <= held_n;
            active   <= act_n;
            note_on  <= |held_n;
            if (ps2_valid) begin
                tmo <= '0;
                unique case (state)
                    IDLE:    state <= (ps2_byte == 8'hF0) ? BRK :
                                      (ps2_byte == 8'hE0) ? EXT : IDLE;
                    EXT:     state <= (ps2_byte == 8'hF0) ? EXTBRK : IDLE;
                    BRK:     state <= IDLE;
                    EXTBRK:  state <= IDLE;
                endcase
            end else if (state != IDLE) begin
                // a stalled prefix is abandoned so a lost byte cannot
                // turn the next make into a break
                if (tmo == TW'(TIMEOUT_CYC - 1)) begin
                    state <= IDLE;
                    tmo   <= '0;
                end else begin
                    tmo <= tmo + TW'(1);
                end
            end else begin
                tmo <= '0;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            tone_req    <= 1'b0;
            tone_period <= '0;
            last_ack    <= '0;
        end else if (tone_req) begin
            if (tone_ack) begin
                last_ack <= tone_period;
                tone_req <= 1'b0;
            end
        end else if (desired != last_ack) begin
            tone_req    <= 1'b1;
            tone_period <= desired;
        end
    end

endmodule
